// File: rtl/bf16_intcast_pipe.sv
// bf16_intcast_pipe: 2-stage BF16 -> integer converter, LANES wide, valid/ready.
// Optional sticky nv/nx flags: define BF16_INTCAST_STICKY_FLAGS_EN.
module bf16_intcast_pipe #(
  parameter int INT_WIDTH = 16,
  parameter int LANES     = 1,
  parameter int TAG_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef BF16_INTCAST_STICKY_FLAGS_EN
  input  logic                       flags_clr,
  output logic                       sticky_nv,
  output logic                       sticky_nx,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*LANES-1:0]        in_data,
  input  logic [2:0]                 in_rnd,
  input  logic                       in_signed,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INT_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]           out_nv,
  output logic [LANES-1:0]           out_nx,
  output logic [TAG_WIDTH-1:0]       out_tag
);

  typedef struct packed {
    logic        sgn;
    logic        nan;
    logic        inf;
    logic        big;
    logic [32:0] ip;
    logic        g;
    logic        st;
  } lane_t;

  localparam logic [33:0] SMAX =
    (34'd1 << (INT_WIDTH - 1)) - 34'd1;
  localparam logic [33:0] SMIN =
    34'd1 << (INT_WIDTH - 1);
  localparam logic [33:0] UMAX =
    (34'd1 << INT_WIDTH) - 34'd1;

  logic                       s1_valid;
  logic                       s2_valid;
  logic                       s1_adv;
  logic                       s2_adv;
  lane_t [LANES-1:0]          s1_lane;
  lane_t [LANES-1:0]          s1_next;
  logic [2:0]                 s1_rnd;
  logic                       s1_signed;
  logic [TAG_WIDTH-1:0]       s1_tag;
  logic [INT_WIDTH*LANES-1:0] s2_data;
  logic [LANES-1:0]           s2_nv;
  logic [LANES-1:0]           s2_nx;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // S1: split into integer part, guard and sticky.
  // Exponents of 33 or more exceed any legal INT_WIDTH.
  always_comb begin
    logic [15:0]       x;
    logic [7:0]        e;
    logic [7:0]        sig;
    logic signed [9:0] ex;
    logic [15:0]       ext;
    lane_t             d;
    s1_next = '0;
    x   = '0;
    e   = '0;
    sig = '0;
    ex  = '0;
    ext = '0;
    d   = '0;
    for (int i = 0; i < LANES; i++) begin
      x     = in_data[16*i +: 16];
      e     = x[14:7];
      sig   = {|e, x[6:0]};
      ex    = (e == 8'd0) ? -10'sd126 :
              $signed({2'b00, e}) - 10'sd127;
      ext   = '0;
      d     = '0;
      d.sgn = x[15];
      if (e == 8'hFF) begin
        d.nan = |x[6:0];
        d.inf = ~|x[6:0];
      end else if (ex >= 10'sd33) begin
        d.big = 1'b1;
      end else if (ex >= 10'sd7) begin
        d.ip = 33'(sig) << 5'(ex - 10'sd7);
      end else if (ex >= -10'sd1) begin
        ext  = {sig, 8'h00} >> 4'(10'sd7 - ex);
        d.ip = 33'(ext[15:8]);
        d.g  = ext[7];
        d.st = |ext[6:0];
      end else begin
        d.st = |sig;
      end
      s1_next[i] = d;
    end
  end

  // S2: round, then clamp to the target range.
  always_comb begin
    lane_t                l;
    logic                 inx;
    logic                 up;
    logic [33:0]          mag;
    logic [33:0]          neg;
    logic [33:0]          pmax;
    logic [INT_WIDTH-1:0] res;
    logic                 nv;
    logic                 nx;
    s2_data = '0;
    s2_nv   = '0;
    s2_nx   = '0;
    l    = '0;
    inx  = 1'b0;
    up   = 1'b0;
    mag  = '0;
    neg  = '0;
    res  = '0;
    nv   = 1'b0;
    nx   = 1'b0;
    pmax = s1_signed ? SMAX : UMAX;
    for (int i = 0; i < LANES; i++) begin
      l   = s1_lane[i];
      inx = l.g | l.st;
      unique case (s1_rnd)
        3'b001:  up = 1'b0;
        3'b010:  up = l.sgn & inx;
        3'b011:  up = !l.sgn & inx;
        3'b100:  up = l.g;
        default: up = l.g & (l.st | l.ip[0]);
      endcase
      mag = 34'(l.ip) + 34'(up);
      neg = ~mag + 34'd1;
      res = '0;
      nv  = 1'b0;
      nx  = 1'b0;
      if (l.nan) begin
        res = pmax[INT_WIDTH-1:0];
        nv  = 1'b1;
      end else if (l.inf) begin
        nv  = 1'b1;
        if (!l.sgn)
          res = pmax[INT_WIDTH-1:0];
        else if (s1_signed)
          res = SMIN[INT_WIDTH-1:0];
      end else if (!l.sgn) begin
        if (l.big || mag > pmax) begin
          res = pmax[INT_WIDTH-1:0];
          nv  = 1'b1;
        end else begin
          res = mag[INT_WIDTH-1:0];
          nx  = inx;
        end
      end else if (s1_signed) begin
        if (l.big || mag > SMIN) begin
          res = SMIN[INT_WIDTH-1:0];
          nv  = 1'b1;
        end else begin
          res = neg[INT_WIDTH-1:0];
          nx  = inx;
        end
      end else begin
        if (l.big || mag != 34'd0)
          nv = 1'b1;
        else
          nx = inx;
      end
      s2_data[INT_WIDTH*i +: INT_WIDTH] = res;
      s2_nv[i] = nv;
      s2_nx[i] = nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lane   <= '0;
      s1_rnd    <= '0;
      s1_signed <= 1'b0;
      s1_tag    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lane   <= s1_next;
        s1_rnd    <= in_rnd;
        s1_signed <= in_signed;
        s1_tag    <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_nv   <= '0;
      out_nx   <= '0;
      out_tag  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_data;
        out_nv   <= s2_nv;
        out_nx   <= s2_nx;
        out_tag  <= s1_tag;
      end
    end
  end

`ifdef BF16_INTCAST_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_nv <= 1'b0;
      sticky_nx <= 1'b0;
    end else if (flags_clr) begin
      sticky_nv <= 1'b0;
      sticky_nx <= 1'b0;
    end else if (out_valid && out_ready) begin
      sticky_nv <= sticky_nv | (|out_nv);
      sticky_nx <= sticky_nx | (|out_nx);
    end
  end
`endif

endmodule

// File: tb/tb_bf16_intcast_pipe.sv
// tb_bf16_intcast_pipe: scoreboard bench, 4 lanes x INT16.
// Expected results come from a real-arithmetic reference model.
module tb_bf16_intcast_pipe;

  localparam int W = 16;
  localparam int L = 4;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [16*L-1:0] in_data = '0;
  logic [2:0]     in_rnd = '0;
  logic           in_signed = 1'b0;
  logic [T-1:0]   in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W*L-1:0] out_data;
  logic [L-1:0]   out_nv;
  logic [L-1:0]   out_nx;
  logic [T-1:0]   out_tag;

  bf16_intcast_pipe #(
    .INT_WIDTH(W),
    .LANES(L),
    .TAG_WIDTH(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_rnd(in_rnd),
    .in_signed(in_signed),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_nv(out_nv),
    .out_nx(out_nx),
    .out_tag(out_tag)
  );

  typedef struct {
    logic [W*L-1:0] d;
    logic [L-1:0]   nv;
    logic [L-1:0]   nx;
    logic [T-1:0]   tag;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [2:0]  r;
    logic        s;
  } vec_t;

  localparam int NDIR = 23;
  vec_t dir [NDIR] = '{
    '{16'h3FC0, 3'd0, 1'b1}, '{16'h3FC0, 3'd1, 1'b1},
    '{16'h4020, 3'd0, 1'b1}, '{16'h4020, 3'd4, 1'b1},
    '{16'hC020, 3'd2, 1'b1}, '{16'hC020, 3'd3, 1'b1},
    '{16'h4700, 3'd0, 1'b1}, '{16'h7FC0, 3'd0, 1'b1},
    '{16'hFF80, 3'd0, 1'b1}, '{16'hBF00, 3'd1, 1'b0},
    '{16'hBF00, 3'd2, 1'b0}, '{16'h0000, 3'd0, 1'b1},
    '{16'h8000, 3'd3, 1'b0}, '{16'h0001, 3'd3, 1'b1},
    '{16'h8001, 3'd2, 1'b1}, '{16'h4020, 3'd7, 1'b1},
    '{16'h4780, 3'd0, 1'b0}, '{16'h477F, 3'd1, 1'b0},
    '{16'hC700, 3'd0, 1'b1}, '{16'hC701, 3'd1, 1'b1},
    '{16'h7F80, 3'd0, 1'b0}, '{16'hFF80, 3'd0, 1'b0},
    '{16'h7FC0, 3'd0, 1'b0}
  };

  exp_t           sbq[$];
  int             nvec = 0;
  int             nerr = 0;
  int             cyc = 0;
  int             acc_cyc = -1;
  int             out_cyc = -1;
  int             stall_cnt = 0;
  logic           pat_on = 1'b0;
  logic           rand_on = 1'b0;
  logic [3:0]     pat = 4'b1001;
  logic           hold_pend = 1'b0;
  logic [W*L-1:0] hold_d = '0;
  logic [T-1:0]   hold_t = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void lane_model(
    input  logic [15:0]  x,
    input  logic [2:0]   rnd,
    input  logic         sgn,
    output logic [W-1:0] res,
    output logic         nv,
    output logic         nx
  );
    real    mag, fl, fr, q, v, hi, lo;
    int     k;
    logic   s, up;
    logic [7:0] e;
    logic [6:0] m;
    longint li;
    s  = x[15];
    e  = x[14:7];
    m  = x[6:0];
    hi = sgn ? real'(longint'(1) << (W - 1)) - 1.0
             : real'(longint'(1) << W) - 1.0;
    lo = sgn ? -real'(longint'(1) << (W - 1)) : 0.0;
    nv = 1'b0;
    nx = 1'b0;
    up = 1'b0;
    if (e == 8'hFF) begin
      nv = 1'b1;
      v  = (m != 0 || !s) ? hi : lo;
    end else begin
      if (e == 8'd0) begin
        mag = real'(int'(m));
        k   = -133;
      end else begin
        mag = real'(128 + int'(m));
        k   = int'(e) - 134;
      end
      while (k > 0) begin mag = mag * 2.0; k--; end
      while (k < 0) begin mag = mag / 2.0; k++; end
      fl = $floor(mag);
      fr = mag - fl;
      case (rnd)
        3'd1: up = 1'b0;
        3'd2: up = s && fr > 0.0;
        3'd3: up = !s && fr > 0.0;
        3'd4: up = fr >= 0.5;
        default:
          up = fr > 0.5 || (fr == 0.5 &&
               (fl - 2.0 * $floor(fl / 2.0)) != 0.0);
      endcase
      q = fl + (up ? 1.0 : 0.0);
      v = s ? -q : q;
      if (v > hi) begin
        v = hi; nv = 1'b1;
      end else if (v < lo) begin
        v = lo; nv = 1'b1;
      end else begin
        nx = (fr != 0.0);
      end
    end
    li  = longint'(v);
    res = li[W-1:0];
  endfunction

  function automatic exp_t model(input logic [16*L-1:0] din,
                                 input logic [2:0] rnd,
                                 input logic sgn,
                                 input logic [T-1:0] tag);
    exp_t         r;
    logic [W-1:0] v;
    logic         a, b;
    r.d   = '0;
    r.nv  = '0;
    r.nx  = '0;
    r.tag = tag;
    for (int i = 0; i < L; i++) begin
      lane_model(din[16*i +: 16], rnd, sgn, v, a, b);
      r.d[W*i +: W] = v;
      r.nv[i] = a;
      r.nx[i] = b;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      acc_cyc   = -1;
      out_cyc   = -1;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_data", 64'(out_data), 64'(hold_d));
        chk("hold_tag", 64'(out_tag), 64'(hold_t));
      end
      hold_pend = out_valid && !out_ready;
      hold_d    = out_data;
      hold_t    = out_tag;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("data", 64'(out_data), 64'(e.d));
          chk("nv", 64'(out_nv), 64'(e.nv));
          chk("nx", 64'(out_nx), 64'(e.nx));
          chk("tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (out_valid && out_cyc < 0) out_cyc = cyc;
      if (in_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        sbq.push_back(model(in_data, in_rnd,
                            in_signed, in_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (pat_on) out_ready = pat[cyc[1:0]];
    else if (rand_on) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [16*L-1:0] d,
                      input logic [2:0] r,
                      input logic s,
                      input logic [T-1:0] tg);
    logic acc;
    int   n;
    in_valid  = 1'b1;
    in_data   = d;
    in_rnd    = r;
    in_signed = s;
    in_tag    = tg;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    chk("accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [16*L-1:0] rnd_lanes(
    input logic [15:0] x0);
    return {16'($urandom), 16'($urandom),
            16'($urandom), x0};
  endfunction

  initial begin
    int st0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_nv", 64'(out_nv), 64'd0);
    chk("rst_out_nx", 64'(out_nx), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    tick();

    for (int i = 0; i < NDIR; i++)
      send(rnd_lanes(dir[i].x), dir[i].r,
           dir[i].s, T'(i));
    drain();
    chk("latency", 64'(out_cyc - acc_cyc), 64'd2);

    pat_on = 1'b1;
    st0 = stall_cnt;
    for (int i = 0; i < 8; i++)
      send(rnd_lanes(16'($urandom)),
           3'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)), T'(i));
    drain();
    pat_on = 1'b0;
    out_ready = 1'b1;
    chk("in_ready_stall", 64'(stall_cnt > st0), 64'd1);

    out_ready = 1'b0;
    send({4{16'h3F80}}, 3'd0, 1'b1, T'(9));
    send({4{16'h4040}}, 3'd0, 1'b1, T'(10));
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_tag", 64'(out_tag), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    tick();
    send(rnd_lanes(16'h4020), 3'd4, 1'b1, T'(11));
    drain();
    chk("rst_latency", 64'(out_cyc - acc_cyc), 64'd2);

    rand_on = 1'b1;
    for (int i = 0; i < 24; i++)
      send({16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom)},
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), T'(i));
    drain();
    rand_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
